// File: rtl/pipe_step_ctrl.sv
// rtl/pipe_step_ctrl.sv - pipeline clock-enable scheduler: run / pause / debounced single-step (optional breakpoint: PIPE_BREAKPOINT_EN)
module pipe_step_ctrl #(
  parameter int DIV_W = 16,
  parameter int DB_W  = 20,
  parameter int PC_W  = 32
) (
  input  logic            clk_in,
  input  logic            rst,
  input  logic            run_sw,
  input  logic            step_btn,
  input  logic [PC_W-1:0] pc,
`ifdef PIPE_BREAKPOINT_EN
  input  logic [PC_W-1:0] bp_addr,
`endif
  output logic            pipe_ce,
  output logic [1:0]      state,
  output logic [15:0]     ce_cnt
);

  typedef enum logic [1:0] {
    S_PAUSE = 2'b00,
    S_RUN   = 2'b01,
    S_STEP  = 2'b10,
    S_BREAK = 2'b11
  } state_t;

  state_t            st;
  state_t            st_next;
  logic              run_q;
  logic              run_s;
  logic              btn_q;
  logic              btn_s;
  logic              db;
  logic              db_d;
  logic [DB_W-1:0]   db_cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic              step_req;
  logic              tick;
  logic              hit;
  logic              ce_next;

  assign step_req = db & ~db_d;
  assign tick     = &div_cnt;
  assign state    = st;

`ifdef PIPE_BREAKPOINT_EN
  assign hit = (pc == bp_addr);
`else
  // Without the breakpoint option the PC is not looked at; fold it into a sink.
  logic unused_pc;
  assign unused_pc = ^pc;
  assign hit       = 1'b0;
`endif

  // Two-flop synchronisers for the asynchronous switch and button.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      run_q <= 1'b0;
      run_s <= 1'b0;
      btn_q <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      run_q <= run_sw;
      run_s <= run_q;
      btn_q <= step_btn;
      btn_s <= btn_q;
    end
  end

  // Debounce: accept a new button level only after it has differed for a full window.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      db     <= 1'b0;
      db_d   <= 1'b0;
      db_cnt <= '0;
    end else begin
      db_d <= db;
      if (btn_s != db) begin
        if (&db_cnt) begin
          db     <= btn_s;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Rate divider: counts only while running, so every RUN entry starts a fresh period.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (st == S_RUN) begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
    end else begin
      div_cnt <= '0;
    end
  end

  // State register.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      st <= S_PAUSE;
    end else begin
      st <= st_next;
    end
  end

  // Next-state and strobe request; a pause in the tick cycle wins over the strobe.
  always_comb begin
    st_next = st;
    ce_next = 1'b0;
    case (st)
      S_PAUSE: begin
        if (run_s) begin
          st_next = S_RUN;
        end else if (step_req) begin
          st_next = S_STEP;
        end
      end
      S_RUN: begin
        if (!run_s) begin
          st_next = S_PAUSE;
        end else if (tick) begin
          if (hit) begin
            st_next = S_BREAK;
          end else begin
            ce_next = 1'b1;
          end
        end
      end
      S_STEP: begin
        ce_next = 1'b1;
        st_next = S_PAUSE;
      end
      S_BREAK: begin
        if (!run_s) begin
          st_next = S_PAUSE;
        end else if (step_req) begin
          st_next = S_STEP;
        end
      end
      default: st_next = S_PAUSE;
    endcase
  end

  // Registered strobe and the running count of strobes issued.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      pipe_ce <= 1'b0;
      ce_cnt  <= '0;
    end else begin
      pipe_ce <= ce_next;
      if (pipe_ce) begin
        ce_cnt <= ce_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_step_ctrl.sv
// tb/tb_pipe_step_ctrl.sv - directed self-checking bench for pipe_step_ctrl (DIV_W=3, DB_W=2)
module tb_pipe_step_ctrl;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        run_sw;
  logic        step_btn;
  logic [7:0]  pc;
  logic [7:0]  bp_addr;
  logic        pipe_ce;
  logic [1:0]  state;
  logic [15:0] ce_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  int cyc        = 0;
  int pulses     = 0;
  int first_at   = -1;
  int last_at    = 0;
  int gap        = 0;
  int adjacent   = 0;
  logic prev_ce  = 1'b0;

  int base;
  int rel;

  pipe_step_ctrl #(
    .DIV_W (3),
    .DB_W  (2),
    .PC_W  (8)
  ) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .run_sw   (run_sw),
    .step_btn (step_btn),
    .pc       (pc),
`ifdef PIPE_BREAKPOINT_EN
    .bp_addr  (bp_addr),
`endif
    .pipe_ce  (pipe_ce),
    .state    (state),
    .ce_cnt   (ce_cnt)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and update the strobe monitor.
  task automatic cyc1();
    @(negedge clk_in);
    cyc++;
    if (pipe_ce) begin
      if (prev_ce) adjacent++;
      if (first_at < 0) first_at = cyc;
      gap     = cyc - last_at;
      last_at = cyc;
      pulses++;
    end
    prev_ce = pipe_ce;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    run_sw   = 1'b0;
    step_btn = 1'b0;
    pc       = 8'h10;
    bp_addr  = 8'h40;
    cyc1();
    cyc1();
    check("reset_ce", {31'd0, pipe_ce}, 32'd0);
    check("reset_state", {30'd0, state}, 32'd0);
    check("reset_cnt", {16'd0, ce_cnt}, 32'd0);
    rst = 1'b0;
    cyc1();

    // Free-run: RUN three edges after the switch, strobes every 8 cycles.
    cyc = 0; pulses = 0; first_at = -1;
    run_sw = 1'b1;
    cyc1();
    cyc1();
    check("run_lat_not_yet", {30'd0, state}, 32'd0);
    cyc1();
    check("run_entry", {30'd0, state}, 32'd1);
    while (cyc < 40) cyc1();
    check("run_pulses", pulses, 32'd4);
    check("run_first_at", first_at, 32'd11);
    check("run_gap", gap, 32'd8);
    check("run_ce_cnt", {16'd0, ce_cnt}, 32'd4);

    // Step button in RUN is ignored.
    step_btn = 1'b1;
    while (cyc < 52) cyc1();
    step_btn = 1'b0;
    while (cyc < 64) cyc1();
    check("runstep_pulses", pulses, 32'd7);
    check("runstep_gap", gap, 32'd8);
    check("runstep_state", {30'd0, state}, 32'd1);
    check("runstep_cnt", {16'd0, ce_cnt}, 32'd7);

    // Pause race: run_s falls exactly in the tick cycle before the strobe at 67.
    run_sw = 1'b0;
    cyc1();
    cyc1();
    check("race_state_66", {30'd0, state}, 32'd1);
    cyc1();
    check("race_state_67", {30'd0, state}, 32'd0);
    while (cyc < 76) cyc1();
    check("race_pulses", pulses, 32'd7);
    check("race_cnt", {16'd0, ce_cnt}, 32'd7);

    // Single step with bounce: exactly one strobe, state 00 -> 10 -> 00.
    base = pulses;
    step_btn = 1'b1;
    cyc1();
    step_btn = 1'b0;
    cyc1();
    step_btn = 1'b1;
    for (int r = 3; r <= 12; r++) begin
      cyc1();
      if (r == 8) check("step_pre_state", {30'd0, state}, 32'd0);
      if (r == 9) check("step_state", {30'd0, state}, 32'd2);
      if (r == 10) begin
        check("step_ce", {31'd0, pipe_ce}, 32'd1);
        check("step_back_pause", {30'd0, state}, 32'd0);
      end
    end
    step_btn = 1'b0;
    for (int r = 0; r < 12; r++) cyc1();
    check("step_one_pulse", pulses - base, 32'd1);
    check("step_cnt", {16'd0, ce_cnt}, 32'd8);
    check("step_release_state", {30'd0, state}, 32'd0);

    // Asynchronous reset while a strobe is high.
    run_sw = 1'b1;
    base = pulses;
    for (int i = 0; i < 40 && pulses == base; i++) cyc1();
    check("rst_pulse_seen", pulses - base, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_ce", {31'd0, pipe_ce}, 32'd0);
    check("rst_async_state", {30'd0, state}, 32'd0);
    check("rst_async_cnt", {16'd0, ce_cnt}, 32'd0);
    run_sw = 1'b0;
    cyc1();
    cyc1();
    rst = 1'b0;
    base = pulses;
    for (int i = 0; i < 20; i++) cyc1();
    check("rst_no_strobe", pulses - base, 32'd0);
    check("rst_idle_state", {30'd0, state}, 32'd0);
    check("rst_idle_cnt", {16'd0, ce_cnt}, 32'd0);

    // Breakpoint at the third tick (pc == 0x40 once two strobes have gone out).
    base = pulses;
    run_sw = 1'b1;
    for (int r = 1; r <= 40; r++) begin
      pc = (pulses - base == 2) ? 8'h40 : 8'h10;
      cyc1();
    end
`ifdef PIPE_BREAKPOINT_EN
    check("bp_pulses", pulses - base, 32'd2);
    check("bp_state", {30'd0, state}, 32'd3);
    check("bp_cnt", {16'd0, ce_cnt}, 32'd2);
    pc = 8'h10;
    step_btn = 1'b1;
    for (rel = 1; rel <= 20; rel++) begin
      cyc1();
      if (rel == 7) check("bp_step_state", {30'd0, state}, 32'd2);
      if (rel == 8) begin
        check("bp_step_ce", {31'd0, pipe_ce}, 32'd1);
        check("bp_step_pause", {30'd0, state}, 32'd0);
      end
      if (rel == 9) check("bp_resume_run", {30'd0, state}, 32'd1);
    end
    step_btn = 1'b0;
    check("bp_resume_pulses", pulses - base, 32'd4);
    check("bp_resume_gap", gap, 32'd9);
    check("bp_resume_cnt", {16'd0, ce_cnt}, 32'd4);
`else
    check("nobp_pulses", pulses - base, 32'd4);
    check("nobp_state", {30'd0, state}, 32'd1);
    check("nobp_cnt", {16'd0, ce_cnt}, 32'd4);
    step_btn = 1'b1;
    for (rel = 1; rel <= 20; rel++) cyc1();
    step_btn = 1'b0;
    check("nobp_cont_pulses", pulses - base, 32'd7);
    check("nobp_cont_gap", gap, 32'd8);
    check("nobp_cont_state", {30'd0, state}, 32'd1);
    check("nobp_cont_cnt", {16'd0, ce_cnt}, 32'd7);
`endif

    check("no_adjacent", adjacent, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pipe_step_ctrl.md
# pipe_step_ctrl

Pipeline clock-enable scheduler for the dynamic pipeline board build. It sits between the raw board clock and the pipeline registers, and produces a single-cycle `pipe_ce` strobe on `clk_in`. Three behaviours:
- free-run at a divided rate (period 2^DIV_W cycles);
- pause;
- single-step from a debounced push-button.

An optional PC breakpoint halts free-run. The pipeline is clocked by `clk_in` and gated by `pipe_ce`.

## Interface
- `DIV_W`, default 16: run-mode strobe period is 2^DIV_W cycles.
- `DB_W`, default 20: debounce window is 2^DB_W cycles.
- `PC_W`, default 32: PC / breakpoint width.

Ports:
- `clk_in`, input, 1: single clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `run_sw`, input, 1: raw run/pause switch (async level).
- `step_btn`, input, 1: raw step push-button (async, bouncy).
- `pc`, input, PC_W: current pipeline PC, synchronous to `clk_in`.
- `bp_addr`, input, PC_W: breakpoint address. Present only with `PIPE_BREAKPOINT_EN`.
- `pipe_ce`, output, 1: registered one-cycle pipeline enable strobe.
- `state`, output, 2: FSM state (00 PAUSE, 01 RUN, 10 STEP, 11 BREAK).
- `ce_cnt`, output, 16: count of `pipe_ce` strobes issued; wraps at 0xFFFF→0.

## Operation
- **Input synchronisation:** `run_sw` and `step_btn` pass through 2-flop synchronisers, giving `run_s` and `btn_s`.
- **Debounce:**
  - Counter `db_cnt` (DB_W bits) increments while `btn_s != db`, and clears when they are equal.
  - When `db_cnt` is all-ones and `btn_s` still differs, `db <= btn_s` and `db_cnt <= 0`.
- **Step request:** `step_req = db & ~db_d` is a one-cycle pulse on a debounced rising edge. Release edges produce nothing.
- **Divider:** `div_cnt` (DIV_W bits) increments only in RUN and is cleared in every other state. `tick = (div_cnt == all-ones)`.
- **FSM transitions:**
  - PAUSE: `run_s=1` → RUN. Otherwise `step_req` → STEP.
  - RUN: `run_s=0` → PAUSE, and any tick in that same cycle is dropped. On `tick & run_s`:
    - with a breakpoint hit: → BREAK, no strobe;
    - otherwise: set `pipe_ce` for the next cycle and wrap `div_cnt` to 0.
    - `step_req` is ignored in RUN.
  - STEP: sets `pipe_ce` for the next cycle, then → PAUSE unconditionally (exactly one strobe per request).
  - BREAK: `run_s=0` → PAUSE. Otherwise `step_req` → STEP. Otherwise hold.
  - Leaving STEP goes to PAUSE; if `run_s=1` it then enters RUN one cycle later, with `div_cnt` starting from 0.
- **Strobe:** `pipe_ce` is high for exactly one cycle per strobe. Two strobes are never adjacent, except a STEP strobe followed by PAUSE→RUN, where the next strobe comes ≥2^DIV_W cycles later.
- **Strobe counter:** `ce_cnt` increments on every cycle `pipe_ce=1`.
- **Reset (asynchronous, any time, including mid-debounce or mid-STEP):** all synchronisers, `db`, `db_d`, `db_cnt`, `div_cnt`, `ce_cnt`, `pipe_ce` → 0, and `state` → PAUSE. No strobe is issued after reset until a new request.

## Timing
- `run_sw` change → state change: 3 edges (2 sync + FSM).
- `step_btn` rising edge (clean) → `pipe_ce` high: 2 sync + 2^DB_W debounce + 1 (`db_d`/FSM to STEP) + 1 (STEP registers `pipe_ce`). This is 2^DB_W+4 cycles, ±1 for input phase.
- RUN strobe period: exactly 2^DIV_W cycles. The first strobe comes 2^DIV_W cycles after entering RUN.
- Breakpoint compare uses `pc` sampled on the tick cycle. There is no PC pipelining inside the block.

## Configuration
- `PIPE_BREAKPOINT_EN` defined:
  - the `bp_addr` port exists;
  - a breakpoint hit is `pc == bp_addr` on a RUN tick;
  - the BREAK state is reachable.
- `PIPE_BREAKPOINT_EN` undefined:
  - no `bp_addr` port and no comparator;
  - the hit term is constant 0;
  - `state` never reads 11, and RUN ticks always strobe.

## Test plan
All scenarios use DIV_W=3 and DB_W=2 unless stated.
- **Reset:** assert `rst` mid-RUN, asynchronously between edges → `pipe_ce=0`, `state=00`, `ce_cnt=0` immediately. No strobe follows while `run_sw=0`.
- **Free-run:** `run_sw=1` held 40 cycles → `state=01` after 3 edges. `pipe_ce` pulses every 8 cycles, first one 8 cycles after RUN entry. `ce_cnt=4` after 40 cycles.
- **Single step with bounce:** in PAUSE, `step_btn` toggles 3 times at 1-cycle intervals, then holds 1 for 10 cycles → exactly one `pipe_ce` pulse, `state` sequence 00→10→00, `ce_cnt=1`. Releasing the button gives no pulse.
- **Pause race:** `run_sw` drops so that `run_s` falls on a tick cycle → no strobe, `state=00`, `ce_cnt` unchanged.
- **Step in RUN:** `step_btn` pressed while in RUN → ignored; strobe spacing stays 8.
- **Breakpoint (macro on):** `bp_addr=0x40`, `pc=0x40` at the 3rd tick → two strobes, then `state=11` with no further strobes. Pressing step → one strobe and `state`→00→01. With the macro off, the same stimulus strobes continuously.
